// File: rtl/pwrbtn_pkg.sv
// Shared constants for the front-panel power-button path: FSM encoding and
// the default millisecond timings used by the detector, BMC mux and sequencer.
package pwrbtn_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS    = 2'd1,
        WAIT_REL = 2'd2
    } state_e;

    localparam int DEF_SHORT_MIN_MS = 50;
    localparam int DEF_LONG_MS      = 4000;
    localparam int DEF_PULSE_MS     = 200;

endpackage

// File: rtl/tick_pulse_stretch.sv
// Turns a one-clock trigger into an active-low level lasting PULSE_TICKS
// strobes. A trigger arriving while the level is already low is ignored.
module tick_pulse_stretch #(
    parameter int PULSE_TICKS = 200
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_trig,
    output logic o_pulse_n
);

    localparam int CW = $clog2(PULSE_TICKS + 1);
    localparam logic [CW-1:0] LAST = CW'(PULSE_TICKS - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        if (active_q) begin
            if (i_tick) begin
                if (cnt_q == LAST) begin
                    active_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        end else if (i_trig) begin
            active_d = 1'b1;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_pulse_n = ~active_q;

endmodule

// File: rtl/pwrbtn_press_detect.sv
// Classifies a filtered, active-low power-button level into short presses
// (stretched into a PCH power-button pulse) and long force-off holds.
module pwrbtn_press_detect
    import pwrbtn_pkg::*;
#(
    parameter int SHORT_MIN_MS = DEF_SHORT_MIN_MS,
    parameter int LONG_MS      = DEF_LONG_MS,
    parameter int PULSE_MS     = DEF_PULSE_MS
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_btn_n,
    input  logic       i_mask,
    output logic       o_short_press,
    output logic       o_long_press,
    output logic       o_btn_active,
    output logic       o_pch_pwrbtn_n,
    output logic [1:0] o_dbg_state
);

    localparam int CW = $clog2(LONG_MS + 1);
    localparam logic [CW-1:0] SHORT_MIN = CW'(SHORT_MIN_MS);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_MS);
    localparam logic [CW-1:0] ONE       = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_prev_q;
    logic          armed_q;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          active_q;
    logic          fall;

    // The first clock after reset only captures the level, so a button held
    // low through reset never looks like a fresh press.
    assign fall = armed_q & btn_prev_q & ~i_btn_n;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fall && !i_mask) begin
                    state_d = PRESS;
                    cnt_d   = '0;
                end
            end
            PRESS: begin
                if (i_mask) begin
                    state_d = i_btn_n ? IDLE : WAIT_REL;
                end else if (i_btn_n) begin
                    state_d = IDLE;
                    short_d = (cnt_q >= SHORT_MIN);
                end else if (i_tick) begin
                    if (cnt_q == LONG_LAST) begin
                        long_d  = 1'b1;
                        state_d = WAIT_REL;
                    end
                    if (cnt_q != LONG_MAX) begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
            WAIT_REL: begin
                if (i_btn_n) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            btn_prev_q <= 1'b1;
            armed_q    <= 1'b0;
            short_q    <= 1'b0;
            long_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            btn_prev_q <= i_btn_n;
            armed_q    <= 1'b1;
            short_q    <= short_d;
            long_q     <= long_d;
            active_q   <= (state_d != IDLE);
        end
    end

    // Triggered from the next-state short decision so the PCH line drops on
    // the same clock that o_short_press rises.
    tick_pulse_stretch #(
        .PULSE_TICKS(PULSE_MS)
    ) u_pch_stretch (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_tick   (i_tick),
        .i_trig   (short_d),
        .o_pulse_n(o_pch_pwrbtn_n)
    );

    assign o_short_press = short_q;
    assign o_long_press  = long_q;
    assign o_btn_active  = active_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_pwrbtn_press_detect.sv
// Bench for pwrbtn_press_detect: directed press scenarios plus random episodes,
// every clock compared against a tick-counting reference model.
module tb_pwrbtn_press_detect;

    localparam int SHORT_MIN = 3;
    localparam int LONG      = 10;
    localparam int PULSE     = 4;
    localparam int TPER      = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       btn_n;
    logic       mask;
    logic       o_short_press;
    logic       o_long_press;
    logic       o_btn_active;
    logic       o_pch_pwrbtn_n;
    logic [1:0] o_dbg_state;

    always #5 clk = ~clk;

    pwrbtn_press_detect #(
        .SHORT_MIN_MS(SHORT_MIN),
        .LONG_MS     (LONG),
        .PULSE_MS    (PULSE)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_tick        (tick),
        .i_btn_n       (btn_n),
        .i_mask        (mask),
        .o_short_press (o_short_press),
        .o_long_press  (o_long_press),
        .o_btn_active  (o_btn_active),
        .o_pch_pwrbtn_n(o_pch_pwrbtn_n),
        .o_dbg_state   (o_dbg_state)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_short, n_long, n_low, n_active;

    logic [3:0] exp_q[$];

    // Reference model: a press is "being timed" from the falling edge until
    // release, mask or the LONG-th tick; afterwards it is "held" until release.
    bit m_prev, m_armed, m_timing, m_holding, m_pulse_on, m_short, m_long;
    int m_ticks, m_pticks;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic model_reset();
        m_prev = 1'b1; m_armed = 1'b0; m_timing = 1'b0; m_holding = 1'b0;
        m_pulse_on = 1'b0; m_short = 1'b0; m_long = 1'b0;
        m_ticks = 0; m_pticks = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit b, input bit mk, input bit tk);
        bit fall, new_short, new_long, pulse_was;
        fall = m_armed && m_prev && !b;
        m_armed = 1'b1;
        m_prev = b;
        new_short = 1'b0;
        new_long = 1'b0;
        if (m_timing) begin
            if (mk) begin
                m_timing = 1'b0;
                m_holding = !b;
            end else if (b) begin
                m_timing = 1'b0;
                new_short = (m_ticks >= SHORT_MIN);
            end else if (tk) begin
                m_ticks++;
                if (m_ticks == LONG) begin
                    new_long = 1'b1;
                    m_timing = 1'b0;
                    m_holding = 1'b1;
                end
            end
        end else if (m_holding) begin
            if (b) m_holding = 1'b0;
        end else if (fall && !mk) begin
            m_timing = 1'b1;
            m_ticks = 0;
        end
        pulse_was = m_pulse_on;
        if (m_pulse_on && tk) begin
            m_pticks++;
            if (m_pticks == PULSE) m_pulse_on = 1'b0;
        end
        if (new_short && !pulse_was) begin
            m_pulse_on = 1'b1;
            m_pticks = 0;
        end
        m_short = new_short;
        m_long = new_long;
        exp_q.push_back({m_short, m_long, (m_timing || m_holding), !m_pulse_on});
    endtask

    // One clock: drive at the falling edge, model at the rising edge,
    // compare at the next falling edge.
    task automatic step(input bit b, input bit mk);
        logic [3:0] want;
        bit tk;
        tk = ((cyc % TPER) == TPER - 1);
        btn_n = b;
        mask = mk;
        tick = tk;
        @(posedge clk);
        model_step(b, mk, tk);
        cyc++;
        @(negedge clk);
        want = exp_q.pop_front();
        expect_eq("short_press", o_short_press, want[3]);
        expect_eq("long_press", o_long_press, want[2]);
        expect_eq("btn_active", o_btn_active, want[1]);
        expect_eq("pch_pwrbtn_n", o_pch_pwrbtn_n, want[0]);
        n_short += int'(o_short_press);
        n_long += int'(o_long_press);
        n_low += int'(!o_pch_pwrbtn_n);
        n_active += int'(o_btn_active);
    endtask

    task automatic idle(input int n, input bit rnd_mask);
        for (int i = 0; i < n; i++) step(1'b1, rnd_mask && ($urandom_range(0, 3) == 0));
    endtask

    task automatic align();
        while ((cyc % TPER) != 0) step(1'b1, 1'b0);
    endtask

    task automatic clear_tallies();
        n_short = 0; n_long = 0; n_low = 0; n_active = 0;
    endtask

    // Hold low until nticks strobes have gone by, then release on the next
    // clock, or on the next strobe clock when on_tick is set.
    task automatic press(input int nticks, input bit on_tick, input bit mk_all, input int mask_at);
        int seen;
        bit tk, mk;
        seen = 0;
        while (seen < nticks) begin
            tk = ((cyc % TPER) == TPER - 1);
            mk = mk_all || (mask_at >= 0 && seen >= mask_at);
            step(1'b0, mk);
            if (tk) seen++;
        end
        mk = mk_all || (mask_at >= 0 && seen >= mask_at);
        if (on_tick) begin
            while ((cyc % TPER) != TPER - 1) step(1'b0, mk);
        end
        step(1'b1, mk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold, mode, mat;
        rst_n = 1'b0; btn_n = 1'b1; mask = 1'b0; tick = 1'b0;
        model_reset();
        clear_tallies();
        repeat (3) @(negedge clk);
        expect_eq("rst_short", o_short_press, 0);
        expect_eq("rst_long", o_long_press, 0);
        expect_eq("rst_active", o_btn_active, 0);
        expect_eq("rst_pch", o_pch_pwrbtn_n, 1);
        expect_eq("rst_state", o_dbg_state, 0);
        rst_n = 1'b1;
        idle(5, 1'b0);

        clear_tallies(); align(); press(2, 1'b0, 1'b0, -1); idle(6, 1'b0);
        expect_eq("runt_no_short", n_short, 0);
        expect_eq("runt_no_pulse", n_low, 0);

        clear_tallies(); align(); press(5, 1'b0, 1'b0, -1); idle(24, 1'b0);
        expect_eq("short_count", n_short, 1);
        expect_eq("short_pulse_width_ok", (n_low >= 12 && n_low <= 20), 1);

        clear_tallies(); align(); press(15, 1'b0, 1'b0, -1); idle(6, 1'b0);
        expect_eq("long_count", n_long, 1);
        expect_eq("long_no_short", n_short, 0);

        clear_tallies(); align(); press(5, 1'b0, 1'b1, -1); idle(6, 1'b0);
        expect_eq("mask_all_no_short", n_short, 0);
        expect_eq("mask_all_no_pulse", n_low, 0);

        clear_tallies(); align(); press(5, 1'b0, 1'b0, 2); idle(6, 1'b0);
        expect_eq("mask_mid_no_short", n_short, 0);
        expect_eq("mask_mid_no_long", n_long, 0);

        clear_tallies(); align(); press(9, 1'b1, 1'b0, -1); idle(24, 1'b0);
        expect_eq("edge_tick_short", n_short, 1);
        expect_eq("edge_tick_no_long", n_long, 0);

        clear_tallies(); align(); press(5, 1'b0, 1'b0, -1); press(3, 1'b0, 1'b0, -1); idle(24, 1'b0);
        expect_eq("retrig_short_count", n_short, 2);
        expect_eq("retrig_width_ok", (n_low >= 12 && n_low <= 20), 1);

        align(); press(5, 1'b0, 1'b0, -1); idle(5, 1'b0);
        expect_eq("pre_reset_pch_low", o_pch_pwrbtn_n, 0);
        #1 rst_n = 1'b0;
        #1;
        expect_eq("async_rst_pch", o_pch_pwrbtn_n, 1);
        expect_eq("async_rst_state", o_dbg_state, 0);
        expect_eq("async_rst_active", o_btn_active, 0);
        model_reset();
        btn_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_tallies();
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        idle(4, 1'b0);
        expect_eq("held_thru_reset_active", n_active, 0);
        expect_eq("held_thru_reset_short", n_short, 0);

        for (int e = 0; e < 40; e++) begin
            idle($urandom_range(1, 6), 1'b1);
            if ($urandom_range(0, 1) == 1) align();
            hold = $urandom_range(0, 13);
            mode = $urandom_range(0, 3);
            mat = (mode == 1) ? $urandom_range(0, hold) : -1;
            press(hold, $urandom_range(0, 2) == 0, mode == 2, mat);
        end
        idle(30, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
